bus_master_arbiter: RTL and testbench
=====================================

BUS_MASTER_ARBITER -- requirements
Module: bus_master_arbiter

Interface
REQ-001 The block SHALL take parameter AddrWidth, default 16, as the bus address width.
REQ-002 The block SHALL take parameter DataWidth, default 32, as the bus data width.
REQ-003 The block SHALL take parameter ReadLatency, default 2, as the WAIT cycles before data_i is captured (legal range 1..15).
REQ-004 The block SHALL take parameter TimeoutCycles, default 1024, as the WAIT cycles before abort (must be greater than ReadLatency).
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port req_i, input, 2 bits: per-requester request, held until ack.
REQ-008 The block SHALL have port we_req_i, input, 2 bits: per-requester write flag (1 = write).
REQ-009 The block SHALL have port addr_req_i, input, 2*AddrWidth bits: requester n address at [n*AddrWidth +: AddrWidth].
REQ-010 The block SHALL have port wdata_req_i, input, 2*DataWidth bits: requester n write data, packed the same way.
REQ-011 The block SHALL have port ack_o, output, 2 bits: one-cycle completion pulse per requester.
REQ-012 The block SHALL have port err_o, output, 2 bits: timeout flag, pulsed together with ack_o.
REQ-013 The block SHALL have port rdata_o, output, DataWidth bits: read data, valid while any ack_o bit is high.
REQ-014 The block SHALL have port address_o, output, AddrWidth bits: shared bus address.
REQ-015 The block SHALL have port data_o, output, DataWidth bits: shared bus write data.
REQ-016 The block SHALL have port we_o, output, 1 bit: shared bus write strobe.
REQ-017 The block SHALL have port data_i, input, DataWidth bits: shared bus read data.
REQ-018 The block SHALL have port halt_i, input, 1 bit: bus stall from slow or CDC slaves.
REQ-019 The block SHALL have port grant_o, output, 2 bits: one-hot current owner, 0 when IDLE.
REQ-020 The block SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-021 The block SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, DONE.
REQ-022 In IDLE with any req_i bit high, the block SHALL select an owner, latch that owner's addr, we and wdata, and move to ISSUE.
REQ-023 Owner selection SHALL be round-robin:
- a single requester wins outright;
- if both request, the one not served last wins.
REQ-024 ISSUE SHALL last exactly one cycle and drive address_o, data_o and we_o from the latched values.
REQ-025 On ISSUE -> WAIT the block SHALL load the latency counter with ReadLatency and clear the timeout counter.
REQ-026 In WAIT, address_o and data_o SHALL hold, and we_o SHALL be 0.
REQ-027 In WAIT with halt_i low, the latency counter SHALL decrement; with halt_i high it SHALL freeze.
REQ-028 In WAIT with the latency counter at 1 and halt_i low, the block SHALL capture data_i into rdata_o (0 for writes) and move to DONE.
REQ-029 The timeout counter SHALL increment every WAIT cycle regardless of halt_i.
REQ-030 When the timeout counter reaches TimeoutCycles, the block SHALL move to DONE with rdata_o = 0 and the err flag set.
REQ-031 DONE SHALL last one cycle:
- ack_o[owner] = 1, and err_o[owner] = 1 if timed out;
- record owner as last served;
- return to IDLE.
REQ-032 Unstalled latency from req_i rising in IDLE to ack_o SHALL be 2+ReadLatency cycles (4 at default).
REQ-033 While not in ISSUE or WAIT, address_o, data_o and we_o SHALL be 0.
REQ-034 After the grant, a withdrawn req_i SHALL be ignored: the transaction completes and ack_o still pulses.
REQ-035 A requester SHALL drop req_i on the edge where it samples ack_o, and IDLE SHALL re-arbitrate on the next cycle.
REQ-036 req_i SHALL be ignored outside IDLE.
REQ-037 we_o SHALL be high for exactly one cycle per write and never for reads.

Reset
REQ-038 On reset_i high at a clock edge, the block SHALL:
- enter IDLE;
- clear all outputs, counters and latched values;
- set last-served = requester 1, so requester 0 wins the first contention.
REQ-039 Reset mid-transaction SHALL abort it silently: no ack_o and no err_o are produced.

Verification
REQ-040 Read by requester 0 at 0x9000, data_i = 0xDEADBEEF -> ack_o[0] 4 cycles after req_i, rdata_o = 0xDEADBEEF, we_o never high.
REQ-041 Write by requester 1 at 0x9004 with 0x12345678 -> we_o high one cycle with address_o = 0x9004 and data_o = 0x12345678, then ack_o[1] 4 cycles after req_i.
REQ-042 Both requesters continuously requesting for 4 transactions after reset -> grant order 0, 1, 0, 1, with each ack_o to the matching requester.
REQ-043 halt_i held high for 5 cycles during WAIT -> ack_o delayed to cycle 9 with correct rdata_o.
REQ-044 halt_i stuck high, TimeoutCycles = 16 -> ack_o[n] and err_o[n] together at cycle 18, rdata_o = 0, and the pending other requester is served next.
REQ-045 reset_i pulsed during WAIT -> no ack_o, all outputs 0 the following cycle, and requester 0 granted first after release.

Source files
------------

// File: rtl/bus_master_arbiter.sv
// Two-requester round-robin bus master arbiter.
// Arbitrates req_i between two requesters, runs one transaction at a time on
// the shared bus, and returns a one-cycle ack_o (plus err_o on timeout).
// Transaction sequence: IDLE -> ISSUE (1 cycle) -> WAIT (latency/timeout) -> DONE (1 cycle).
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   req_i, we_req_i        per-requester request / write flag
//   addr_req_i             requester n address at [n*AddrWidth +: AddrWidth]
//   wdata_req_i            requester n write data at [n*DataWidth +: DataWidth]
//   ack_o, err_o           per-requester completion pulse / timeout flag
//   rdata_o                read data, valid while ack_o is non-zero
//   address_o, data_o      shared bus address / write data
//   we_o                   shared bus write strobe (ISSUE cycle only)
//   data_i, halt_i         shared bus read data / stall
//   grant_o, busy_o        one-hot current owner / non-IDLE indicator
module bus_master_arbiter #(
  parameter int AddrWidth     = 16,
  parameter int DataWidth     = 32,
  parameter int ReadLatency   = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [1:0]             req_i,
  input  logic [1:0]             we_req_i,
  input  logic [2*AddrWidth-1:0] addr_req_i,
  input  logic [2*DataWidth-1:0] wdata_req_i,
  output logic [1:0]             ack_o,
  output logic [1:0]             err_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [AddrWidth-1:0]   address_o,
  output logic [DataWidth-1:0]   data_o,
  output logic                   we_o,
  input  logic [DataWidth-1:0]   data_i,
  input  logic                   halt_i,
  output logic [1:0]             grant_o,
  output logic                   busy_o
);
  localparam int ToW = $clog2(TimeoutCycles + 1);
  localparam logic [3:0]     LatInit = 4'(ReadLatency);
  localparam logic [ToW-1:0] ToLast  = ToW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
  } xact_t;

  state_e               state_q, state_d;
  xact_t                xact_q, xact_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;
  logic [3:0]           lat_q, lat_d;
  logic [ToW-1:0]       to_q, to_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 pick;
  logic [1:0]           owner_oh;

  // Lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    unique case (req_i)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~last_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      xact_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      lat_q   <= '0;
      to_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      xact_q  <= xact_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    xact_d  = xact_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = err_q;
    lat_d   = lat_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: if (|req_i) begin
        owner_d      = pick;
        xact_d.we    = pick ? we_req_i[1] : we_req_i[0];
        xact_d.addr  = pick ? addr_req_i[2*AddrWidth-1:AddrWidth] : addr_req_i[AddrWidth-1:0];
        xact_d.wdata = pick ? wdata_req_i[2*DataWidth-1:DataWidth] : wdata_req_i[DataWidth-1:0];
        err_d        = 1'b0;
        rdata_d      = '0;
        state_d      = ISSUE;
      end
      ISSUE: begin
        lat_d   = LatInit;
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Timeout counts stalled cycles too; normal completion wins a tie.
        to_d = to_q + 1'b1;
        if (!halt_i) lat_d = lat_q - 4'd1;
        if (!halt_i && lat_q == 4'd1) begin
          rdata_d = xact_q.we ? '0 : data_i;
          state_d = DONE;
        end else if (to_q == ToLast) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign owner_oh  = owner_q ? 2'b10 : 2'b01;
  assign grant_o   = (state_q != IDLE) ? owner_oh : 2'b00;
  assign busy_o    = (state_q != IDLE);
  assign ack_o     = (state_q == DONE) ? owner_oh : 2'b00;
  assign err_o     = ack_o & {2{err_q}};
  assign rdata_o   = (state_q == DONE) ? rdata_q : '0;
  assign address_o = (state_q == ISSUE || state_q == WAIT) ? xact_q.addr : '0;
  assign data_o    = (state_q == ISSUE || state_q == WAIT) ? xact_q.wdata : '0;
  assign we_o      = (state_q == ISSUE) && xact_q.we;
endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter: directed scenarios followed by randomized
// traffic, checked cycle by cycle against a transaction-level model.
// The model precomputes halt_i/data_i per cycle and derives each
// transaction's ack cycle, data and err flag from the latency/timeout rules.
module tb_bus_master_arbiter;
  localparam int AW = 16, DW = 32, RL = 2, TO = 16, NCYC = 3000;

  logic          clk_i = 1'b0, reset_i = 1'b1;
  logic [1:0]    req_i = '0, we_req_i = '0;
  logic [2*AW-1:0] addr_req_i = '0;
  logic [2*DW-1:0] wdata_req_i = '0;
  logic [1:0]    ack_o, err_o, grant_o;
  logic [DW-1:0] rdata_o, data_o;
  logic [DW-1:0] data_i = '0;
  logic [AW-1:0] address_o;
  logic          we_o, busy_o;
  logic          halt_i = 1'b0;

  always #5 clk_i = ~clk_i;

  bus_master_arbiter #(.AddrWidth(AW), .DataWidth(DW), .ReadLatency(RL), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .we_req_i(we_req_i),
    .addr_req_i(addr_req_i), .wdata_req_i(wdata_req_i), .ack_o(ack_o), .err_o(err_o),
    .rdata_o(rdata_o), .address_o(address_o), .data_o(data_o), .we_o(we_o),
    .data_i(data_i), .halt_i(halt_i), .grant_o(grant_o), .busy_o(busy_o)
  );

  int n_chk = 0, n_err = 0, cyc = 0;
  int p_arr = 0, p_drop = 0;

  // per-cycle bus environment
  bit            halt_a [NCYC];
  logic [DW-1:0] din_a  [NCYC];

  // requester side
  bit            pend [2];
  bit            drv  [2];
  logic          rw   [2];
  logic [AW-1:0] ra   [2];
  logic [DW-1:0] rd   [2];

  // model of the transaction in flight
  bit            m_act = 0, m_err, m_we;
  int            m_own, m_g, m_ack, m_last = 1;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d, m_rd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic arrive(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[n] = 1; drv[n] = 1; rw[n] = w; ra[n] = a; rd[n] = d;
  endtask

  task automatic step();
    int cnt;
    bit in_t;
    logic [1:0] g, ex_ack;
    // requester drops req the cycle after its ack
    if (m_act && cyc == m_ack + 1) begin
      m_act = 0; pend[m_own] = 0; drv[m_own] = 0; m_last = m_own;
    end
    for (int n = 0; n < 2; n++)
      if (!pend[n] && $urandom_range(0, 99) < p_arr)
        arrive(n, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
    if (!m_act && (drv[0] || drv[1])) begin
      m_own = (drv[0] && drv[1]) ? 1 - m_last : (drv[1] ? 1 : 0);
      m_g = cyc; m_we = rw[m_own]; m_a = ra[m_own]; m_d = rd[m_own];
      m_err = 1; m_ack = cyc + 2 + TO; m_rd = '0; cnt = 0;
      // ReadLatency unstalled WAIT cycles needed; TO WAIT cycles allowed
      for (int k = cyc + 2; k < cyc + 2 + TO; k++)
        if (!halt_a[k]) begin
          cnt++;
          if (cnt == RL) begin
            m_ack = k + 1; m_err = 0; m_rd = m_we ? '0 : din_a[k];
            break;
          end
        end
      m_act = 1;
    end else if (m_act && cyc > m_g) begin
      // owner may withdraw and scribble its fields after the grant
      if ($urandom_range(0, 99) < p_drop) drv[m_own] = 0;
      ra[m_own] = AW'($urandom); rd[m_own] = $urandom; rw[m_own] = 1'($urandom_range(0, 1));
    end
    req_i = {drv[1], drv[0]}; we_req_i = {rw[1], rw[0]};
    addr_req_i = {ra[1], ra[0]}; wdata_req_i = {rd[1], rd[0]};
    halt_i = halt_a[cyc]; data_i = din_a[cyc];
    #1;
    in_t   = m_act && cyc > m_g && cyc <= m_ack;
    g      = in_t ? (m_own ? 2'b10 : 2'b01) : 2'b00;
    ex_ack = (m_act && cyc == m_ack) ? g : 2'b00;
    chk("grant", grant_o, g);
    chk("busy", busy_o, in_t);
    chk("ack", ack_o, ex_ack);
    chk("err", err_o, m_err ? ex_ack : 2'b00);
    chk("addr", address_o, (in_t && cyc < m_ack) ? m_a : '0);
    chk("wdata", data_o, (in_t && cyc < m_ack) ? m_d : '0);
    chk("we", we_o, m_act && cyc == m_g + 1 && m_we);
    if (ex_ack != 2'b00) chk("rdata", rdata_o, m_rd);
    @(posedge clk_i); #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_i = 1; req_i = '0; halt_i = 0;
    @(posedge clk_i); #1;
    chk("rst_ack", ack_o, 2'b00);
    chk("rst_err", err_o, 2'b00);
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_addr", address_o, '0);
    chk("rst_data", data_o, '0);
    chk("rst_we", we_o, 1'b0);
    chk("rst_rdata", rdata_o, '0);
    reset_i = 0;
    m_act = 0; m_last = 1;
    for (int n = 0; n < 2; n++) begin pend[n] = 0; drv[n] = 0; end
    cyc++;
  endtask

  initial begin
    for (int k = 0; k < NCYC; k++) begin
      halt_a[k] = (k >= 400) && (($urandom_range(0, 99) < 25) || (k % 250 < 20));
      din_a[k]  = $urandom;
    end
    for (int n = 0; n < 2; n++) begin rw[n] = 0; ra[n] = '0; rd[n] = '0; end
    @(posedge clk_i); #1;
    do_reset();

    // single read, requester 0
    for (int k = cyc; k < cyc + 8; k++) din_a[k] = 32'hDEADBEEF;
    arrive(0, 1'b0, 16'h9000, '0);
    repeat (8) step();

    // single write, requester 1
    arrive(1, 1'b1, 16'h9004, 32'h12345678);
    repeat (8) step();

    // both requesting continuously from reset: 0,1,0,1
    do_reset();
    p_arr = 100;
    repeat (22) step();
    p_arr = 0;
    repeat (12) step();

    // 5-cycle stall during WAIT
    for (int k = cyc + 2; k <= cyc + 6; k++) halt_a[k] = 1;
    arrive(0, 1'b0, AW'($urandom), '0);
    repeat (12) step();

    // stuck halt: timeout on first, pending other served next
    for (int k = cyc; k < cyc + 25; k++) halt_a[k] = 1;
    arrive(0, 1'b0, AW'($urandom), '0);
    arrive(1, 1'b1, AW'($urandom), $urandom);
    repeat (45) step();

    // reset in WAIT aborts silently; requester 0 wins afterwards
    arrive(1, 1'b0, AW'($urandom), '0);
    repeat (3) step();
    do_reset();
    arrive(0, 1'b1, AW'($urandom), $urandom);
    arrive(1, 1'b0, AW'($urandom), '0);
    repeat (14) step();

    // randomized traffic with stalls, timeouts and withdrawn requests
    p_arr = 40; p_drop = 30;
    while (cyc < NCYC - TO - 8) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
